// File: rtl/song_sequencer.sv
// -----------------------------------------------------------------------------
// song_sequencer
//
// Walks one song at a time through an external synchronous song ROM and hands
// each {note, duration} entry to the note player. An entry is fetched,
// captured, announced with a one-cycle load_new_note pulse, and the sequencer
// then waits for the note player's note_done before moving to the next entry.
// Also handles play/pause, song selection, restart on song change and
// end-of-song detection (zero duration end marker or the last index).
//
// Build option:
//   SONG_LOOP_EN  - when defined, the end of a song pulses song_done for one
//                   cycle and the song restarts from entry 0 (DONE is never
//                   entered). When undefined, the sequencer parks in DONE with
//                   song_done held high until the song changes or reset.
//
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset
//   play             1 = run/advance, 0 = pause
//   song             selected song
//   rom_addr         {song_latched, note_index} to the song ROM
//   rom_data         {note[11:6], duration[5:0]}, valid one cycle after rom_addr
//   note_to_load     registered note for the note player
//   duration_to_load registered duration for the note player
//   load_new_note    one-cycle pulse, note/duration valid
//   note_done        note player has finished the current note
//   note_index       index of the current entry
//   song_done        end of song reached
// -----------------------------------------------------------------------------
module song_sequencer #(
    parameter int SONG_BITS  = 2,
    parameter int INDEX_BITS = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            play,
    input  logic [SONG_BITS-1:0]            song,
    output logic [SONG_BITS+INDEX_BITS-1:0] rom_addr,
    input  logic [11:0]                     rom_data,
    output logic [5:0]                      note_to_load,
    output logic [5:0]                      duration_to_load,
    output logic                            load_new_note,
    input  logic                            note_done,
    output logic [INDEX_BITS-1:0]           note_index,
    output logic                            song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        LOAD,
        PLAY,
        DONE
    } state_t;

    state_t                  state, state_d;
    logic [SONG_BITS-1:0]    song_latched, song_d;
    logic [INDEX_BITS-1:0]   index_d;
    logic [5:0]              note_d, duration_d;
    logic                    done_d;
    logic                    end_hit;
    logic                    song_changed;

    // The ROM address is always the current entry of the latched song.
    assign rom_addr      = {song_latched, note_index};
    // The pulse is a pure decode of the state register, so it lasts exactly
    // the one cycle spent in LOAD.
    assign load_new_note = (state == LOAD);

    // A new selection restarts the song from any state except IDLE, where the
    // selection is simply tracked until play starts.
    assign song_changed  = (state != IDLE) && (song != song_latched);

    // NOTE: every registered value is held in its own state register and
    // updated with non-blocking assignments, so all of them see the same
    // pre-edge values no matter how the statements are ordered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            note_index       <= '0;
            song_latched     <= '0;
            note_to_load     <= '0;
            duration_to_load <= '0;
            song_done        <= 1'b0;
        end else begin
            state            <= state_d;
            note_index       <= index_d;
            song_latched     <= song_d;
            note_to_load     <= note_d;
            duration_to_load <= duration_d;
            song_done        <= done_d;
        end
    end

    // NOTE: every value produced here is given a default before any branch,
    // so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state;
        index_d    = note_index;
        song_d     = song_latched;
        note_d     = note_to_load;
        duration_d = duration_to_load;
`ifdef SONG_LOOP_EN
        done_d     = 1'b0;          // song_done is only ever a one-cycle pulse
`else
        done_d     = song_done;     // held until a song change or reset
`endif
        end_hit    = 1'b0;

        if (song_changed) begin
            // Song change wins over note_done and any pending capture; the
            // old song's pending entry is dropped without a load pulse.
            song_d  = song;
            index_d = '0;
            done_d  = 1'b0;
            state_d = FETCH;
        end else begin
            case (state)
                IDLE: begin
                    song_d = song;
                    if (play) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (play) begin
                        state_d = WAIT_ROM;
                    end
                end
                WAIT_ROM: begin
                    // The capture happens even while paused so the fetched
                    // entry is never lost; only the state advance waits.
                    note_d     = rom_data[11:6];
                    duration_d = rom_data[5:0];
                    if (play) begin
                        if (rom_data[5:0] == 6'd0) begin
                            end_hit = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
                LOAD: begin
                    state_d = PLAY;
                end
                PLAY: begin
                    if (note_done && play) begin
                        if (&note_index) begin
                            end_hit = 1'b1;
                        end else begin
                            index_d = note_index + INDEX_BITS'(1);
                            state_d = FETCH;
                        end
                    end
                end
                DONE: begin
                    // Parked; only a song change or reset leaves.
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (end_hit) begin
`ifdef SONG_LOOP_EN
                done_d  = 1'b1;
                index_d = '0;
                state_d = FETCH;
`else
                done_d  = 1'b1;
                state_d = DONE;
`endif
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// -----------------------------------------------------------------------------
// tb_song_sequencer
//
// Bench for song_sequencer. A behavioural song ROM (registered read) sits on
// rom_addr/rom_data. Directed scenarios check reset, latency, song change,
// pause, end marker and reset mid-play; a randomised run plays a full 32-entry
// song with random pauses and random note lengths, comparing every load
// against the list of entries the song table says should be played.
// -----------------------------------------------------------------------------
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic [1:0]  song;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_to_load;
    logic [5:0]  duration_to_load;
    logic        load_new_note;
    logic        note_done;
    logic [4:0]  note_index;
    logic        song_done;

    int total = 0;
    int bad   = 0;

    logic [11:0] rom [0:127];

    typedef struct {
        logic [4:0] idx;
        logic [5:0] note;
        logic [5:0] dur;
    } load_t;

    load_t expq[$];

    song_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .play             (play),
        .song             (song),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .note_to_load     (note_to_load),
        .duration_to_load (duration_to_load),
        .load_new_note    (load_new_note),
        .note_done        (note_done),
        .note_index       (note_index),
        .song_done        (song_done)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM: data appears one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Advance one clock and land 1 time unit after the edge, where outputs
    // are sampled and new inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; play = 1'b0; note_done = 1'b0; song = 2'd1;
        tick();
        tick();
        total++;
        if ({rom_addr, note_to_load, duration_to_load, load_new_note, note_index, song_done} !== 28'd0)
            begin bad++; $display("FAIL reset_outputs: got addr=%h note=%0d dur=%0d load=%b idx=%0d done=%b, want all 0",
                                  rom_addr, note_to_load, duration_to_load, load_new_note, note_index, song_done); end
    endtask

    // play sampled in IDLE at edge N: FETCH, WAIT_ROM, LOAD on the next three cycles.
    task automatic test_first_load();
        play = 1'b1;
        reset = 1'b0;
        tick();
        total++;
        if (rom_addr !== 7'h20) begin bad++; $display("FAIL first_addr: got %h want 20", rom_addr); end
        total++;
        if (load_new_note !== 1'b0) begin bad++; $display("FAIL first_early_load1: got %b want 0", load_new_note); end
        tick();
        total++;
        if (load_new_note !== 1'b0) begin bad++; $display("FAIL first_early_load2: got %b want 0", load_new_note); end
        tick();
        total++;
        if (load_new_note !== 1'b1) begin bad++; $display("FAIL first_load_pulse: got %b want 1", load_new_note); end
        total++;
        if ({note_to_load, duration_to_load} !== {6'd12, 6'd6})
            begin bad++; $display("FAIL first_load_data: got note=%0d dur=%0d want note=12 dur=6", note_to_load, duration_to_load); end
        tick();
        total++;
        if (load_new_note !== 1'b0) begin bad++; $display("FAIL first_load_width: got %b want 0", load_new_note); end
    endtask

    // Song change in the same cycle as note_done: restart song 2 at entry 0.
    task automatic test_song_change();
        logic [11:0] e;
        e = rom[64];
        song = 2'd2;
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
        total++;
        if ({rom_addr, note_index, song_done, load_new_note} !== {7'h40, 5'd0, 1'b0, 1'b0})
            begin bad++; $display("FAIL change_restart: got addr=%h idx=%0d done=%b load=%b want addr=40 idx=0 done=0 load=0",
                                  rom_addr, note_index, song_done, load_new_note); end
        tick();
        total++;
        if (load_new_note !== 1'b0) begin bad++; $display("FAIL change_no_old_load: got %b want 0", load_new_note); end
        tick();
        total++;
        if ({load_new_note, note_to_load, duration_to_load} !== {1'b1, e[11:6], e[5:0]})
            begin bad++; $display("FAIL change_rest_load: got load=%b note=%0d dur=%0d want load=1 note=%0d dur=%0d",
                                  load_new_note, note_to_load, duration_to_load, e[11:6], e[5:0]); end
        tick();
    endtask

    // Back to song 1, then note_done advances to entry 1 with a load three
    // cycles after the note_done edge.
    task automatic test_advance();
        logic [11:0] e;
        e = rom[33];
        song = 2'd1;
        tick();
        total++;
        if (rom_addr !== 7'h20) begin bad++; $display("FAIL advance_restart_addr: got %h want 20", rom_addr); end
        tick();
        tick();
        total++;
        if ({load_new_note, note_to_load} !== {1'b1, 6'd12})
            begin bad++; $display("FAIL advance_first: got load=%b note=%0d want load=1 note=12", load_new_note, note_to_load); end
        tick();
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
        total++;
        if ({note_index, load_new_note} !== {5'd1, 1'b0})
            begin bad++; $display("FAIL advance_index: got idx=%0d load=%b want idx=1 load=0", note_index, load_new_note); end
        tick();
        total++;
        if (load_new_note !== 1'b0) begin bad++; $display("FAIL advance_early_load: got %b want 0", load_new_note); end
        tick();
        total++;
        if ({load_new_note, note_to_load, duration_to_load, note_index} !== {1'b1, e[11:6], e[5:0], 5'd1})
            begin bad++; $display("FAIL advance_load: got load=%b note=%0d dur=%0d idx=%0d want load=1 note=%0d dur=%0d idx=1",
                                  load_new_note, note_to_load, duration_to_load, note_index, e[11:6], e[5:0]); end
        tick();
    endtask

    // note_done while paused is ignored; once play returns a single note_done
    // gives exactly one advance.
    task automatic test_pause();
        int loads;
        int moved;
        loads = 0;
        moved = 0;
        play = 1'b0;
        for (int k = 0; k < 2; k++) begin
            note_done = 1'b1;
            tick();
            note_done = 1'b0;
            if (load_new_note) loads++;
            if (note_index != 5'd1) moved++;
            tick();
            if (load_new_note) loads++;
            if (note_index != 5'd1) moved++;
        end
        total++;
        if (loads != 0) begin bad++; $display("FAIL pause_no_load: got %0d loads want 0", loads); end
        total++;
        if (moved != 0) begin bad++; $display("FAIL pause_index_frozen: got %0d moved samples want 0", moved); end
        play = 1'b1;
        note_done = 1'b1;
        tick();
        note_done = 1'b0;
        total++;
        if (note_index !== 5'd2) begin bad++; $display("FAIL pause_single_advance: got idx=%0d want 2", note_index); end
    endtask

    // Entry 2 of song 1 carries the zero-duration end marker.
    task automatic test_end_marker();
        tick();
        tick();
        total++;
        if ({song_done, load_new_note, duration_to_load} !== {1'b1, 1'b0, 6'd0})
            begin bad++; $display("FAIL end_detect: got done=%b load=%b dur=%0d want done=1 load=0 dur=0",
                                  song_done, load_new_note, duration_to_load); end
`ifdef SONG_LOOP_EN
        tick();
        total++;
        if (song_done !== 1'b0) begin bad++; $display("FAIL end_pulse_width: got %b want 0", song_done); end
        tick();
        total++;
        if ({load_new_note, note_to_load, duration_to_load, note_index} !== {1'b1, 6'd12, 6'd6, 5'd0})
            begin bad++; $display("FAIL end_loop_reload: got load=%b note=%0d dur=%0d idx=%0d want load=1 note=12 dur=6 idx=0",
                                  load_new_note, note_to_load, duration_to_load, note_index); end
        tick();
`else
        begin
            int held;
            int loads;
            held = 0;
            loads = 0;
            for (int k = 0; k < 5; k++) begin
                tick();
                if (song_done) held++;
                if (load_new_note) loads++;
            end
            total++;
            if ({held, loads} !== {32'd5, 32'd0})
                begin bad++; $display("FAIL end_hold: got done_cycles=%0d loads=%0d want 5 and 0", held, loads); end
            total++;
            if (note_index !== 5'd2) begin bad++; $display("FAIL end_index: got %0d want 2", note_index); end
        end
`endif
    endtask

    // Full 32-entry song 0 with random pauses and random note lengths.
    task automatic test_max_index();
        load_t got;
        load_t want;
        logic [11:0] e0;
        int accepted;
        int cycles;
        int early_done;
        bit awaiting;
        bit drove_done;
        bit drove_play;
        bit just_loaded;
        int sd_cycles;
        int post_loads;
        int post_bad;

        expq.delete();
        for (int i = 0; i < 32; i++) begin
            logic [11:0] e;
            e = rom[i];
            expq.push_back('{idx: 5'(i), note: e[11:6], dur: e[5:0]});
        end
        e0 = rom[0];

        accepted = 0;
        cycles = 0;
        early_done = 0;
        awaiting = 1'b0;
        drove_done = 1'b0;
        drove_play = 1'b1;
        song = 2'd0;
        play = 1'b1;
        note_done = 1'b0;

        while (accepted < 32 && cycles < 3000) begin
            tick();
            cycles++;
            if (drove_done && drove_play) begin
                awaiting = 1'b0;
                accepted++;
                if (accepted == 32) break;
            end
            if (song_done) early_done++;
            just_loaded = 1'b0;
            if (load_new_note) begin
                just_loaded = 1'b1;
                awaiting = 1'b1;
                got = '{idx: note_index, note: note_to_load, dur: duration_to_load};
                total++;
                if (expq.size() == 0) begin
                    bad++; $display("FAIL max_extra_load: got idx=%0d want no load", got.idx);
                end else begin
                    want = expq.pop_front();
                    if ({got.idx, got.note, got.dur} !== {want.idx, want.note, want.dur}) begin
                        bad++;
                        $display("FAIL max_load: got idx=%0d note=%0d dur=%0d want idx=%0d note=%0d dur=%0d",
                                 got.idx, got.note, got.dur, want.idx, want.note, want.dur);
                    end
                end
            end
            play = ($urandom_range(3, 0) != 0);
            note_done = awaiting && !just_loaded && ($urandom_range(2, 0) == 0);
            drove_done = note_done;
            drove_play = play;
        end
        note_done = 1'b0;
        play = 1'b1;

        total++;
        if (accepted != 32) begin bad++; $display("FAIL max_timeout: got %0d notes finished want 32", accepted); end
        total++;
        if (expq.size() != 0) begin bad++; $display("FAIL max_missing: got %0d entries never loaded want 0", expq.size()); end
        total++;
        if (early_done != 0) begin bad++; $display("FAIL max_early_done: got %0d cycles want 0", early_done); end

        // Observe the end: the current sample plus eight more cycles.
        sd_cycles = song_done ? 1 : 0;
        post_loads = load_new_note ? 1 : 0;
        post_bad = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (song_done) sd_cycles++;
            if (load_new_note) begin
                post_loads++;
                if ({note_index, note_to_load, duration_to_load} !== {5'd0, e0[11:6], e0[5:0]}) post_bad++;
            end
        end
`ifdef SONG_LOOP_EN
        total++;
        if ({sd_cycles, post_loads, post_bad} !== {32'd1, 32'd1, 32'd0})
            begin bad++; $display("FAIL max_loop_end: got done_cycles=%0d loads=%0d wrong_loads=%0d want 1 1 0",
                                  sd_cycles, post_loads, post_bad); end
`else
        total++;
        if ({sd_cycles, post_loads} !== {32'd9, 32'd0})
            begin bad++; $display("FAIL max_done_hold: got done_cycles=%0d loads=%0d want 9 and 0", sd_cycles, post_loads); end
        total++;
        if (note_index !== 5'd31) begin bad++; $display("FAIL max_done_index: got %0d want 31", note_index); end
`endif
    endtask

    // Reset while a note is playing clears everything on the next cycle.
    task automatic test_reset_mid_play();
        bit seen;
        seen = 1'b0;
        song = 2'd1;
        play = 1'b1;
        note_done = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (load_new_note) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL midreset_no_load: got no load in 20 cycles want one"); end
        tick();
        reset = 1'b1;
        tick();
        total++;
        if ({rom_addr, note_to_load, duration_to_load, load_new_note, note_index, song_done} !== 28'd0)
            begin bad++; $display("FAIL midreset_outputs: got addr=%h note=%0d dur=%0d load=%b idx=%0d done=%b, want all 0",
                                  rom_addr, note_to_load, duration_to_load, load_new_note, note_index, song_done); end
        reset = 1'b0;
        play = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            rom[i] = {6'($urandom), 6'($urandom_range(63, 1))};
        end
        rom[32] = {6'd12, 6'd6};                         // song 1, entry 0
        rom[34] = {6'($urandom), 6'd0};                  // song 1, entry 2: end marker
        rom[64] = {6'd0, 6'($urandom_range(63, 1))};     // song 2, entry 0: a rest

        test_reset();
        test_first_load();
        test_song_change();
        test_advance();
        test_pause();
        test_end_marker();
        test_max_index();
        test_reset_mid_play();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
